// File: rtl/mcp_launch_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : mcp_launch_arb_pkg
// Brief    : Shared types and state decode positions for the MCP launch arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mcp_launch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } state_t;

  // One-hot-ish encoding lets single bits stand in for full state compares.
  localparam int c_ST_LAUNCH_BIT = 0;
  localparam int c_ST_WAIT_BIT   = 1;

endpackage : mcp_launch_arb_pkg

`default_nettype wire

// File: rtl/mcp_launch_arb_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: lowest index at or above ptr with
//            req set, wrapping. Returns a one-hot grant and its index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  localparam logic [PTR_W:0] c_N = (PTR_W+1)'(N);

  logic [PTR_W:0] w_pos;

  // Walk offsets from far to near so the nearest requester at or above ptr
  // is the last writer and wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    w_pos = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_pos >= c_N) begin
        w_pos = w_pos - c_N;
      end
      if (req[w_pos[PTR_W-1:0]]) begin
        gnt                    = '0;
        gnt[w_pos[PTR_W-1:0]]  = 1'b1;
        idx                    = w_pos[PTR_W-1:0];
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/mcp_launch_arb.sv
//------------------------------------------------------------------------------
// Module   : mcp_launch_arb
// Brief    : Round-robin sharing of one MCP launch interface between N
//            requesters; optional busy watchdog under MCP_LAUNCH_ARB_TMO_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mcp_launch_arb
  import mcp_launch_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int TMO_W = 8
) (
  input  logic           l_clk,
  input  logic           l_rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   req_done,
  output logic           l_in_pass_r,
  output logic [W-1:0]   l_in_r,
  input  logic           l_busy_r,
  output logic           err_tmo_r
);

  localparam int                 c_PTR_W    = $clog2(N);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N-1);
  localparam logic [N-1:0]       c_ONE      = N'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] r_gnt_idx;
  logic [c_PTR_W-1:0] w_arb_idx;
  logic [c_PTR_W-1:0] w_ptr_nxt;
  logic [N-1:0]       w_arb_gnt;
  logic [W-1:0]       w_win_data;
  logic               w_grant;
  logic               w_done;
  logic               w_tmo;

  rr_arbiter #(
    .N     (N),
    .PTR_W (c_PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx)
  );

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_arb_gnt[i]) begin
        w_win_data = req_data[i*W +: W];
      end
    end
  end

  // Grant is gated by reset so no ack escapes while the block is held in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (l_rst_n && (|req_valid) && !l_busy_r) begin
          w_grant     = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (!l_busy_r) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req_ack   = w_grant ? w_arb_gnt : '0;
  assign req_done  = w_done ? (c_ONE << r_gnt_idx) : '0;
  assign w_ptr_nxt = (r_gnt_idx == c_LAST_IDX) ? '0 : (r_gnt_idx + c_PTR_W'(1));

  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      l_in_pass_r <= 1'b0;
      l_in_r      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      l_in_pass_r <= w_grant;
      if (w_grant) begin
        l_in_r    <= w_win_data;
        r_gnt_idx <= w_arb_idx;
      end
      if (w_done || w_tmo) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef MCP_LAUNCH_ARB_TMO_EN
  localparam logic [TMO_W-1:0] c_TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Fires on the WAIT cycle whose increment reaches all-ones.
  assign w_tmo = r_state[c_ST_WAIT_BIT] && l_busy_r && (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      r_tmo_cnt <= '0;
      err_tmo_r <= 1'b0;
    end else begin
      if (r_state[c_ST_LAUNCH_BIT]) begin
        r_tmo_cnt <= '0;
      end else if (r_state[c_ST_WAIT_BIT] && l_busy_r) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (w_tmo) begin
        err_tmo_r <= 1'b1;
      end
    end
  end
`else
  assign w_tmo     = 1'b0;
  // TMO_W is always >= 1, so this is constant 0.
  assign err_tmo_r = (TMO_W < 1);
`endif

endmodule : mcp_launch_arb

`default_nettype wire

// File: tb/tb_mcp_launch_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_mcp_launch_arb
// Brief    : Directed self-checking bench for mcp_launch_arb with a small MCP
//            busy model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mcp_launch_arb;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int TMO_W = 4;

  logic           l_clk = 1'b0;
  logic           l_rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   req_done;
  logic           l_in_pass_r;
  logic [W-1:0]   l_in_r;
  logic           l_busy_r;
  logic           err_tmo_r;

  int             busy_len;
  logic           busy_force;
  int             mcp_cnt = 0;
  int             cyc = 0;

  int             n_total = 0;
  int             n_bad   = 0;
  int             ack_q[$];
  logic [W-1:0]   pass_q[$];
  int             pass_n = 0;
  int             done_n = 0;

  mcp_launch_arb #(
    .N     (N),
    .W     (W),
    .TMO_W (TMO_W)
  ) u_dut (
    .l_clk       (l_clk),
    .l_rst_n     (l_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .req_done    (req_done),
    .l_in_pass_r (l_in_pass_r),
    .l_in_r      (l_in_r),
    .l_busy_r    (l_busy_r),
    .err_tmo_r   (err_tmo_r)
  );

  always #5 l_clk = ~l_clk;

  always @(posedge l_clk) cyc <= cyc + 1;

  // MCP model: busy for busy_len cycles starting the cycle after the pass.
  always @(posedge l_clk) begin
    if (l_in_pass_r) begin
      mcp_cnt <= busy_len;
    end else if (mcp_cnt != 0) begin
      mcp_cnt <= mcp_cnt - 1;
    end
  end
  assign l_busy_r = busy_force | (mcp_cnt != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge l_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge l_clk);
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int at);
    d  = '0;
    at = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge l_clk);
      if (|req_done) begin
        d  = req_done;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    l_rst_n = 1'b0;
    tick();
    tick();
    l_rst_n = 1'b1;
    tick();
  endtask

  // Event monitor: records grants and passes, checks pulse exclusivity.
  initial begin
    forever begin
      @(negedge l_clk);
      if (|req_ack) begin
        ack_q.push_back(idx_of(req_ack));
        check("ack_onehot", {31'b0, $onehot(req_ack)}, 32'd1);
      end
      if (|req_done) begin
        done_n++;
        check("done_onehot", {31'b0, $onehot(req_done)}, 32'd1);
      end
      if ((|req_ack) || (|req_done)) begin
        check("ack_done_excl", {31'b0, (|req_ack) && (|req_done)}, 32'd0);
      end
      if (l_in_pass_r) begin
        pass_n++;
        pass_q.push_back(l_in_r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] d;
    int           at;
    int           t0;
    int           p0;
    int           d0;
    int           exp2[5] = '{0, 1, 2, 3, 0};
    int           exp3[3] = '{2, 3, 2};

    l_rst_n    = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    busy_force = 1'b0;
    busy_len   = 6;

    // Reset values
    tick();
    smp();
    check("rst_ack", req_ack, 0);
    check("rst_done", req_done, 0);
    check("rst_pass", l_in_pass_r, 0);
    check("rst_data", l_in_r, 0);
    check("rst_err", err_tmo_r, 0);
    tick();
    l_rst_n = 1'b1;
    tick();
    tick();

    // Single request
    req_data[0*W +: W] = 32'hDEADBEEF;
    req_valid = 4'b0001;
    t0 = cyc;
    smp();
    check("t1_ack", req_ack, 4'b0001);
    check("t1_pass_early", l_in_pass_r, 0);
    tick();
    req_valid = '0;
    smp();
    check("t1_pass", l_in_pass_r, 1);
    check("t1_data", l_in_r, 32'hDEADBEEF);
    wait_done(d, at);
    check("t1_done", d, 4'b0001);
    check("t1_done_cyc", at - t0, 8);
    check("t1_data_hold", l_in_r, 32'hDEADBEEF);

    // All four requesters continuously valid
    do_reset();
    busy_len = 2;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h10 + i;
    ack_q.delete();
    pass_q.delete();
    p0 = pass_n;
    d0 = done_n;
    req_valid = 4'b1111;
    for (int k = 0; k < 200 && ack_q.size() < 5; k++) smp();
    tick();
    req_valid = '0;
    repeat (12) tick();
    check("t2_grants", ack_q.size(), 5);
    for (int i = 0; i < 5 && i < ack_q.size(); i++) begin
      check("t2_order", ack_q[i], exp2[i]);
      if (i < pass_q.size()) check("t2_pass_data", pass_q[i], 32'h10 + exp2[i]);
    end
    check("t2_passes", pass_n - p0, 5);
    check("t2_pass_per_done", pass_n - p0, done_n - d0);

    // Requester 2 re-requests while 3 is pending
    ack_q.delete();
    req_valid = 4'b1100;
    for (int k = 0; k < 200 && ack_q.size() < 3; k++) smp();
    tick();
    req_valid = '0;
    repeat (12) tick();
    check("t3_grants", ack_q.size(), 3);
    for (int i = 0; i < 3 && i < ack_q.size(); i++) check("t3_order", ack_q[i], exp3[i]);

    // Busy high at reset release
    l_rst_n    = 1'b0;
    busy_force = 1'b1;
    req_valid  = 4'b1000;
    ack_q.delete();
    p0 = pass_n;
    tick();
    tick();
    l_rst_n = 1'b1;
    repeat (5) tick();
    smp();
    check("t4_no_ack", ack_q.size(), 0);
    check("t4_no_pass", pass_n - p0, 0);
    tick();
    busy_force = 1'b0;
    smp();
    check("t4_ack", req_ack, 4'b1000);
    tick();
    req_valid = '0;
    wait_done(d, at);
    check("t4_done", d, 4'b1000);

    // Asynchronous reset mid-WAIT
    tick();
    busy_len  = 10;
    req_valid = 4'b0001;
    req_data[0*W +: W] = 32'hCAFE0001;
    smp();
    check("t5_ack", req_ack, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    d0 = done_n;
    #2;
    l_rst_n = 1'b0;
    #1;
    check("t5_rst_ack", req_ack, 0);
    check("t5_rst_done", req_done, 0);
    check("t5_rst_pass", l_in_pass_r, 0);
    check("t5_rst_data", l_in_r, 0);
    check("t5_rst_err", err_tmo_r, 0);
    tick();
    tick();
    l_rst_n = 1'b1;
    repeat (12) tick();
    check("t5_no_done", done_n - d0, 0);
    req_valid = 4'b0010;
    smp();
    check("t5_idle_ack", req_ack, 4'b0010);
    tick();
    req_valid = '0;
    wait_done(d, at);
    check("t5_done", d, 4'b0010);

    // Busy stuck high in WAIT
    tick();
    busy_len  = 2;
    req_valid = 4'b0001;
    smp();
    check("t6_ack", req_ack, 4'b0001);
    tick();
    req_valid  = '0;
    busy_force = 1'b1;
    d0 = done_n;
`ifdef MCP_LAUNCH_ARB_TMO_EN
    repeat (15) tick();
    smp();
    check("t6_err_pre", err_tmo_r, 0);
    tick();
    smp();
    check("t6_err", err_tmo_r, 1);
    check("t6_no_done", done_n - d0, 0);
    tick();
    req_valid = 4'b0110;
    smp();
    check("t6_busy_block", req_ack, 0);
    tick();
    busy_force = 1'b0;
    smp();
    check("t6_next_ack", req_ack, 4'b0010);
    check("t6_err_sticky", err_tmo_r, 1);
    tick();
    req_valid = '0;
    wait_done(d, at);
    check("t6_next_done", d, 4'b0010);
`else
    repeat (40) tick();
    smp();
    check("t6_err_off", err_tmo_r, 0);
    check("t6_still_wait", done_n - d0, 0);
    tick();
    busy_force = 1'b0;
    wait_done(d, at);
    check("t6_done", d, 4'b0001);
    check("t6_err_off_end", err_tmo_r, 0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_mcp_launch_arb

`default_nettype wire
